collision_scanner: RTL and testbench
====================================

Name: collision_scanner

Overview:
- Parametrised next-generation collision unit for the racing game.
- Once per frame, on `frame_tick`, it snapshots the player car position and N enemy positions.
- It then scans the enemies sequentially, one per clock, using a full axis-aligned rectangle-overlap test with per-object sizes.
- It reports a collision flag (sticky or per-frame), the lowest hitting enemy index, a hit mask and a saturating collision counter to the game-control FSM.

Parameters:
- N_ENEMIES, 4, number of enemy channels (>=1).
- COORD_W, 10, width of every X/Y coordinate.
- CAR_W, 80, car box width in pixels.
- CAR_H, 121, car box height in pixels.
- ENEMY_W, 80, enemy box width in pixels.
- ENEMY_H, 121, enemy box height in pixels.
- STICKY, 1, 1 = `collision` latches until `clear`/reset; 0 = `collision` reflects the latest completed scan only.
- CNT_W, 8, width of `collision_count`.
- IDX_W, max(1, clog2(N_ENEMIES)), localparam, width of the index.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  start-scan request, sampled only in IDLE
- clear  in  1  clears sticky `collision` and `collision_count`
- enemy_active  in  N_ENEMIES  per-enemy enable; bit i = 0 means enemy i is never hit
- enemy_pos_x  in  N_ENEMIES*COORD_W  packed; enemy i at bits [i*COORD_W +: COORD_W]
- enemy_pos_y  in  N_ENEMIES*COORD_W  packed, same layout
- car_pos_x  in  COORD_W  car top-left X
- car_pos_y  in  COORD_W  car top-left Y
- busy  out  1  high in SCAN and DONE
- scan_done  out  1  one-cycle pulse when results update
- collision  out  1  collision flag
- hit_index  out  IDX_W  lowest hitting enemy index of the last scan that had a hit
- hit_mask  out  N_ENEMIES  per-enemy hit bits of the last completed scan
- collision_count  out  CNT_W  number of scans with >=1 hit, saturating at all-ones

Behaviour:
- **Reset.** The reset is synchronous and active-high. While `reset` is high at a clock edge:
  - state <= IDLE and the scan index is cleared;
  - all outputs go to 0 (`busy`, `scan_done`, `collision`, `hit_index`, `hit_mask`, `collision_count`).
  - Reset takes priority over everything. A reset mid-scan aborts the scan and produces no `scan_done`.
- **FSM states.** IDLE, SCAN, DONE.
  - IDLE: on `frame_tick`=1, register the car position, all enemy positions and `enemy_active` into snapshot registers. Clear the working hit mask, set idx <= 0 and go to SCAN.
  - SCAN: each cycle, test snapshot enemy idx. Set working_mask[idx] if `enemy_active`[idx] and the boxes overlap. If idx == N_ENEMIES-1, go to DONE; otherwise idx <= idx+1.
  - DONE: for one cycle, drive `scan_done`=1 and outputs already reflecting the completed scan, then return to IDLE.
- **Latency.** With `frame_tick` sampled at edge k, `scan_done` is high in the cycle after edge k+N_ENEMIES. The next `frame_tick` is accepted no earlier than the edge that ends DONE.
- **Ignored ticks.** `frame_tick` while `busy` is ignored; there is no queueing.
- **Overlap test (inclusive edges).** A hit requires all four conditions:
  - car_x <= ex+ENEMY_W
  - ex <= car_x+CAR_W
  - car_y <= ey+ENEMY_H
  - ey <= car_y+CAR_H
  - Additions and compares are done at COORD_W+1 bits, zero-extended; there is no wrap-around.
- **Result update.** On the edge entering DONE:
  - `hit_mask` <= final working mask.
  - If any bit is set: `hit_index` <= lowest set index, `collision_count` increments (saturating), and `collision` <= 1.
  - If no bit is set: `hit_index` holds its previous value; `collision` holds its value if STICKY=1, or goes to 0 if STICKY=0.
  - Only snapshot values are used, so input changes during a scan have no effect.
- **Clear.** `clear`=1 at an edge sets `collision` and `collision_count` to 0. `hit_mask` and `hit_index` are untouched.
  - If `clear` coincides with a result update, `clear` wins for `collision`/`collision_count`, while `hit_mask`/`hit_index` still update.
  - `clear` does not affect scan progress.

Test Plan:
1. Reset, then car (100,200), enemy0 (150,250) active, others far/inactive, `frame_tick` 1 cycle -> `scan_done` 5 cycles after the tick edge; `collision`=1, `hit_index`=0, `hit_mask`=0001, `collision_count`=1.
2. Inclusive-boundary check with car (100,200):
   - enemy1 x=180, y=200 -> hit, mask=0010.
   - Move to x=181 -> next scan mask=0000; `collision` stays 1 (STICKY=1), and goes to 0 in a STICKY=0 build.
3. Enemies 1 and 3 overlap, enemy 2 overlaps but `enemy_active`[2]=0 -> `hit_mask`=1010, `hit_index`=1.
4. No-wrap check: car x=1010, enemy0 x=1000 (1000+80 needs 11 bits), y equal -> hit. `frame_tick` pulsed again mid-scan -> ignored, exactly one `scan_done`.
5. `clear` asserted in the DONE-entry cycle of a hitting scan -> `collision`=0, `collision_count`=0, `hit_mask` updated. A further 256 hitting scans with CNT_W=8 -> `collision_count` saturates at 255.
6. `reset` asserted 2 cycles into SCAN -> next cycle `busy`=0, all outputs 0, no `scan_done`. A new `frame_tick` then completes normally.

Source files
------------

// File: rtl/collision_scanner.sv
// Per-frame collision unit: snapshots car and enemy positions on frame_tick, then
// tests one enemy per clock with an inclusive rectangle-overlap check and publishes the result.
module collision_scanner #(
   parameter int N_ENEMIES = 4,
   parameter int COORD_W   = 10,
   parameter int CAR_W     = 80,
   parameter int CAR_H     = 121,
   parameter int ENEMY_W   = 80,
   parameter int ENEMY_H   = 121,
   parameter int STICKY    = 1,
   parameter int CNT_W     = 8,
   localparam int IDX_W    = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           frame_tick,
   input  logic                           clear,
   input  logic [N_ENEMIES-1:0]           enemy_active,
   input  logic [N_ENEMIES*COORD_W-1:0]   enemy_pos_x,
   input  logic [N_ENEMIES*COORD_W-1:0]   enemy_pos_y,
   input  logic [COORD_W-1:0]             car_pos_x,
   input  logic [COORD_W-1:0]             car_pos_y,
   output logic                           busy,
   output logic                           scan_done,
   output logic                           collision,
   output logic [IDX_W-1:0]               hit_index,
   output logic [N_ENEMIES-1:0]           hit_mask,
   output logic [CNT_W-1:0]               collision_count
);

   localparam int CW1 = COORD_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENEMIES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                         state_q, state_d;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [N_ENEMIES-1:0]           work_q, work_d;
   logic                           load_s;

   logic [COORD_W-1:0]             car_x_q, car_y_q;
   logic [N_ENEMIES*COORD_W-1:0]   ex_q, ey_q;
   logic [N_ENEMIES-1:0]           act_q;

   logic                           busy_q, busy_d;
   logic                           done_q, done_d;
   logic                           coll_q, coll_d;
   logic [IDX_W-1:0]               hit_index_q, hit_index_d;
   logic [N_ENEMIES-1:0]           hit_mask_q, hit_mask_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;

   logic [COORD_W-1:0]             ex_sel_s, ey_sel_s;
   logic [CW1-1:0]                 car_x_s, car_y_s, ex_s, ey_s;
   logic                           overlap_s, hit_now_s;
   logic [N_ENEMIES-1:0]           final_mask_s;
   logic [IDX_W-1:0]               lowest_s;

   // Overlap test of the currently indexed snapshot enemy, widened by one bit so sums never wrap.
   always_comb begin
      ex_sel_s  = ex_q[idx_q*COORD_W +: COORD_W];
      ey_sel_s  = ey_q[idx_q*COORD_W +: COORD_W];
      car_x_s   = {1'b0, car_x_q};
      car_y_s   = {1'b0, car_y_q};
      ex_s      = {1'b0, ex_sel_s};
      ey_s      = {1'b0, ey_sel_s};
      overlap_s = (car_x_s <= ex_s + CW1'(ENEMY_W)) &&
                  (ex_s <= car_x_s + CW1'(CAR_W)) &&
                  (car_y_s <= ey_s + CW1'(ENEMY_H)) &&
                  (ey_s <= car_y_s + CW1'(CAR_H));
      hit_now_s    = act_q[idx_q] & overlap_s;
      final_mask_s = work_q | (N_ENEMIES'(hit_now_s) << idx_q);
      lowest_s     = '0;
      for (int i = N_ENEMIES - 1; i >= 0; i--) begin
         if (final_mask_s[i]) begin
            lowest_s = IDX_W'(i);
         end else begin
            lowest_s = lowest_s;
         end
      end
   end

   // Next-state and result logic; clear overrides the flag and counter after any update.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      work_d      = work_q;
      load_s      = 1'b0;
      coll_d      = coll_q;
      hit_index_d = hit_index_q;
      hit_mask_d  = hit_mask_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (frame_tick) begin
               load_s  = 1'b1;
               work_d  = '0;
               idx_d   = '0;
               state_d = S_SCAN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            work_d = final_mask_s;
            if (idx_q == LAST_IDX) begin
               state_d    = S_DONE;
               hit_mask_d = final_mask_s;
               if (|final_mask_s) begin
                  hit_index_d = lowest_s;
                  coll_d      = 1'b1;
                  cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
               end else begin
                  coll_d = (STICKY != 0) ? coll_q : 1'b0;
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (clear) begin
         coll_d = 1'b0;
         cnt_d  = '0;
      end else begin
         coll_d = coll_d;
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // Control state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         work_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         coll_q      <= 1'b0;
         hit_index_q <= '0;
         hit_mask_q  <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         work_q      <= work_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         coll_q      <= coll_d;
         hit_index_q <= hit_index_d;
         hit_mask_q  <= hit_mask_d;
         cnt_q       <= cnt_d;
      end
   end

   // Frame snapshot so input changes mid-scan cannot disturb the result.
   always_ff @(posedge clk) begin
      if (reset) begin
         car_x_q <= '0;
         car_y_q <= '0;
         ex_q    <= '0;
         ey_q    <= '0;
         act_q   <= '0;
      end else if (load_s) begin
         car_x_q <= car_pos_x;
         car_y_q <= car_pos_y;
         ex_q    <= enemy_pos_x;
         ey_q    <= enemy_pos_y;
         act_q   <= enemy_active;
      end
   end

   assign busy            = busy_q;
   assign scan_done       = done_q;
   assign collision       = coll_q;
   assign hit_index       = hit_index_q;
   assign hit_mask        = hit_mask_q;
   assign collision_count = cnt_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner: a frame-level timeline model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_collision_scanner;

   localparam int N      = 4;
   localparam int CW     = 10;
   localparam int IW     = 2;
   localparam int CNTW   = 8;
   localparam int STICKY = 1;
   localparam int CAR_W  = 80;
   localparam int CAR_H  = 121;
   localparam int EN_W   = 80;
   localparam int EN_H   = 121;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            frame_tick = 1'b0;
   logic            clear = 1'b0;
   logic [N-1:0]    enemy_active = '0;
   logic [N*CW-1:0] enemy_pos_x = '0;
   logic [N*CW-1:0] enemy_pos_y = '0;
   logic [CW-1:0]   car_pos_x = '0;
   logic [CW-1:0]   car_pos_y = '0;
   logic            busy, scan_done, collision;
   logic [IW-1:0]   hit_index;
   logic [N-1:0]    hit_mask;
   logic [CNTW-1:0] collision_count;

   int checks = 0;
   int errors = 0;

   collision_scanner #(
      .N_ENEMIES(N), .COORD_W(CW), .CAR_W(CAR_W), .CAR_H(CAR_H),
      .ENEMY_W(EN_W), .ENEMY_H(EN_H), .STICKY(STICKY), .CNT_W(CNTW)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .clear(clear),
      .enemy_active(enemy_active), .enemy_pos_x(enemy_pos_x), .enemy_pos_y(enemy_pos_y),
      .car_pos_x(car_pos_x), .car_pos_y(car_pos_y),
      .busy(busy), .scan_done(scan_done), .collision(collision),
      .hit_index(hit_index), .hit_mask(hit_mask), .collision_count(collision_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: a busy countdown per accepted frame, results computed arithmetically.
   int           m_rem = 0;
   bit           m_valid = 1'b0;
   logic [N-1:0] m_pend = '0;
   logic [N-1:0] m_mask = '0;
   logic [IW-1:0] m_idx = '0;
   bit           m_coll = 1'b0;
   int           m_cnt = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_rem = 0; m_mask = '0; m_idx = '0; m_coll = 1'b0; m_cnt = 0; m_valid = 1'b1;
      end else begin
         if (m_rem == 0) begin
            if (frame_tick) begin
               int cx, cy, ex, ey;
               cx = int'(car_pos_x);
               cy = int'(car_pos_y);
               for (int i = 0; i < N; i++) begin
                  ex = int'(enemy_pos_x[i*CW +: CW]);
                  ey = int'(enemy_pos_y[i*CW +: CW]);
                  m_pend[i] = enemy_active[i] && (cx <= ex + EN_W) && (ex <= cx + CAR_W) &&
                              (cy <= ey + EN_H) && (ey <= cy + CAR_H);
               end
               m_rem = N + 1;
            end
         end else begin
            m_rem--;
            if (m_rem == 1) begin
               m_mask = m_pend;
               if (m_pend != '0) begin
                  for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_idx = IW'(i);
                  m_coll = 1'b1;
                  if (m_cnt < 255) m_cnt++;
               end else if (STICKY == 0) begin
                  m_coll = 1'b0;
               end
            end
         end
         if (clear) begin
            m_coll = 1'b0;
            m_cnt = 0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         chk("busy", busy, (m_rem > 0));
         chk("scan_done", scan_done, (m_rem == 1));
         chk("collision", collision, m_coll);
         chk("hit_index", hit_index, m_idx);
         chk("hit_mask", hit_mask, m_mask);
         chk("collision_count", collision_count, m_cnt);
      end
   end

   logic [CW-1:0] ex [N];
   logic [CW-1:0] ey [N];

   task automatic drive(input int cx, input int cy, input logic [N-1:0] act);
      car_pos_x = CW'(cx);
      car_pos_y = CW'(cy);
      enemy_active = act;
      for (int i = 0; i < N; i++) begin
         enemy_pos_x[i*CW +: CW] = ex[i];
         enemy_pos_y[i*CW +: CW] = ey[i];
      end
   endtask

   task automatic far_all();
      for (int i = 0; i < N; i++) begin
         ex[i] = CW'(600);
         ey[i] = CW'(700);
      end
   endtask

   // Starts a frame at the current negedge and observes 12 cycles; event offsets count negedges.
   task automatic run_scan(input int clear_at, input int tick2_at, input int reset_at,
                           input int scramble_at, output int done_c, output int n_done);
      frame_tick = 1'b1;
      done_c = 0;
      n_done = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         frame_tick = (c == tick2_at);
         clear = (c == clear_at);
         reset = (c == reset_at);
         if (c == scramble_at) begin
            enemy_active = '0;
            enemy_pos_x = '1;
            car_pos_x = '0;
         end
         if (reset_at > 0 && c == reset_at + 1) begin
            chk("rst_busy", busy, 1'b0);
            chk("rst_coll", collision, 1'b0);
            chk("rst_mask", hit_mask, 4'b0000);
            chk("rst_cnt", collision_count, 8'd0);
         end
         if (scan_done === 1'b1) begin
            n_done++;
            if (done_c == 0) done_c = c;
         end
      end
   endtask

   int dc, nd;

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("init_busy", busy, 1'b0);
      chk("init_coll", collision, 1'b0);
      chk("init_cnt", collision_count, 8'd0);
      chk("init_idx", hit_index, 2'd0);

      // Basic hit on enemy 0.
      far_all();
      ex[0] = CW'(150); ey[0] = CW'(250);
      drive(100, 200, 4'b0001);
      run_scan(0, 0, 0, 0, dc, nd);
      chk("t1_latency", dc, 5);
      chk("t1_ndone", nd, 1);
      chk("t1_coll", collision, 1'b1);
      chk("t1_idx", hit_index, 2'd0);
      chk("t1_mask", hit_mask, 4'b0001);
      chk("t1_cnt", collision_count, 8'd1);

      // Inclusive x boundary, then one pixel beyond.
      far_all();
      ex[1] = CW'(180); ey[1] = CW'(200);
      drive(100, 200, 4'b0010);
      run_scan(0, 0, 0, 0, dc, nd);
      chk("t2_mask", hit_mask, 4'b0010);
      chk("t2_idx", hit_index, 2'd1);
      chk("t2_cnt", collision_count, 8'd2);
      ex[1] = CW'(181);
      drive(100, 200, 4'b0010);
      run_scan(0, 0, 0, 0, dc, nd);
      chk("t2b_mask", hit_mask, 4'b0000);
      chk("t2b_coll_sticky", collision, 1'b1);
      chk("t2b_idx_hold", hit_index, 2'd1);
      chk("t2b_cnt", collision_count, 8'd2);

      // Enemy 2 overlaps but is disabled; inputs scrambled mid-scan.
      far_all();
      ex[1] = CW'(120); ey[1] = CW'(220);
      ex[2] = CW'(100); ey[2] = CW'(200);
      ex[3] = CW'(50);  ey[3] = CW'(150);
      drive(100, 200, 4'b1011);
      run_scan(0, 0, 0, 2, dc, nd);
      chk("t3_mask", hit_mask, 4'b1010);
      chk("t3_idx", hit_index, 2'd1);
      chk("t3_cnt", collision_count, 8'd3);

      // Sum needing the extra bit; second tick mid-scan ignored.
      far_all();
      ex[0] = CW'(1000); ey[0] = CW'(200);
      drive(1010, 200, 4'b0001);
      run_scan(0, 2, 0, 0, dc, nd);
      chk("t4_ndone", nd, 1);
      chk("t4_mask", hit_mask, 4'b0001);
      chk("t4_idx", hit_index, 2'd0);
      chk("t4_cnt", collision_count, 8'd4);

      // Clear on the result edge, then saturate the counter.
      far_all();
      ex[0] = CW'(150); ey[0] = CW'(250);
      drive(100, 200, 4'b0001);
      run_scan(4, 0, 0, 0, dc, nd);
      chk("t5_coll", collision, 1'b0);
      chk("t5_cnt", collision_count, 8'd0);
      chk("t5_mask", hit_mask, 4'b0001);
      for (int s = 0; s < 256; s++) run_scan(0, 0, 0, 0, dc, nd);
      chk("t5_sat", collision_count, 8'd255);
      chk("t5_coll2", collision, 1'b1);

      // Reset two cycles into the scan aborts it; a fresh frame then completes.
      drive(100, 200, 4'b0001);
      run_scan(0, 0, 2, 0, dc, nd);
      chk("t6_ndone", nd, 0);
      run_scan(0, 0, 0, 0, dc, nd);
      chk("t6_ndone2", nd, 1);
      chk("t6_cnt", collision_count, 8'd1);
      chk("t6_coll", collision, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
